// File: rtl/lfsr_pkg.sv
// Shared definitions for the 32-bit LFSR stage and its downstream checker.
package lfsr_pkg;

    localparam logic [31:0] TAP_MASK = 32'h088C_8892;

    typedef enum logic [1:0] {
        SEARCH,
        SYNC,
        LOCKED
    } chk_state_t;

    // Advance the LFSR by one step: shift left and feed the tap parity into bit 0.
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return {s[30:0], ^(s & TAP_MASK)};
    endfunction

endpackage

// File: rtl/lfsr_checker.sv
// Locks onto an LFSR word stream, then flywheels its own prediction to flag
// corrupted or dropped words. Reports lock status, error pulses and
// saturating word/error counters.
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int LOCK_COUNT = 8,
    parameter int ERR_LIMIT  = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             clear_i,
    input  logic             data_valid_i,
    input  logic [31:0]      data_i,
    output logic             locked_o,
    output logic             err_o,
    output logic [CNT_W-1:0] err_count_o,
    output logic [CNT_W-1:0] word_count_o
);

    localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
    localparam int MISS_W = $clog2(ERR_LIMIT + 1);
    localparam logic [GOOD_W-1:0] LOCK_N = GOOD_W'(LOCK_COUNT);
    localparam logic [MISS_W-1:0] MISS_N = MISS_W'(ERR_LIMIT);

    chk_state_t        state_q, state_d;
    logic [31:0]       pred_q, pred_d;
    logic [GOOD_W-1:0] good_q, good_d;
    logic [MISS_W-1:0] miss_q, miss_d;
    logic              locked_q, locked_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;

    logic [GOOD_W-1:0] good_inc;
    logic [MISS_W-1:0] miss_inc;

    // Counters stick at all-ones rather than wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    assign good_inc = good_q + GOOD_W'(1);
    assign miss_inc = miss_q + MISS_W'(1);

    // Next-state, prediction and counter updates for each accepted word.
    always_comb begin
        state_d    = state_q;
        pred_d     = pred_q;
        good_d     = good_q;
        miss_d     = miss_q;
        err_d      = 1'b0;
        err_cnt_d  = err_cnt_q;
        word_cnt_d = word_cnt_q;
        if (data_valid_i) begin
            unique case (state_q)
                SEARCH: begin
                    // All-zero is the LFSR lockup value and can never seed.
                    if (data_i != 32'd0) begin
                        pred_d  = lfsr_next(data_i);
                        good_d  = '0;
                        state_d = SYNC;
                    end
                end
                SYNC: begin
                    if (data_i == 32'd0) begin
                        state_d = SEARCH;
                    end else if (data_i == pred_q) begin
                        pred_d = lfsr_next(data_i);
                        good_d = good_inc;
                        if (good_inc == LOCK_N) begin
                            state_d = LOCKED;
                            miss_d  = '0;
                        end
                    end else begin
                        // Reseed from the new word and start counting again.
                        pred_d = lfsr_next(data_i);
                        good_d = '0;
                    end
                end
                LOCKED: begin
                    // Flywheel: the prediction only ever advances from itself,
                    // so a corrupt word cannot pull the checker off sequence.
                    pred_d     = lfsr_next(pred_q);
                    word_cnt_d = sat_inc(word_cnt_q);
                    if (data_i == pred_q) begin
                        miss_d = '0;
                    end else begin
                        err_d     = 1'b1;
                        err_cnt_d = sat_inc(err_cnt_q);
                        miss_d    = miss_inc;
                        if (miss_inc == MISS_N) state_d = SEARCH;
                    end
                end
                default: state_d = SEARCH;
            endcase
        end
        if (clear_i) begin
            err_cnt_d  = '0;
            word_cnt_d = '0;
        end
        locked_d = (state_d == LOCKED);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= SEARCH;
            pred_q     <= '0;
            good_q     <= '0;
            miss_q     <= '0;
            locked_q   <= 1'b0;
            err_q      <= 1'b0;
            err_cnt_q  <= '0;
            word_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            pred_q     <= pred_d;
            good_q     <= good_d;
            miss_q     <= miss_d;
            locked_q   <= locked_d;
            err_q      <= err_d;
            err_cnt_q  <= err_cnt_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    assign locked_o     = locked_q;
    assign err_o        = err_q;
    assign err_count_o  = err_cnt_q;
    assign word_count_o = word_cnt_q;

endmodule
